id_ex_reg: RTL and testbench
============================

Name: id_ex_reg

Overview:
- ID/EX pipeline register of the 5-stage 64-bit RISC-V style pipeline; sits between the decode stage (control unit, register file, immediate generator) and the execute stage (ALU, forwarding unit, hazard logic).
- Captures decode-stage control bits, operand data, register addresses and the immediate on every rising clock edge.
- Presents them unchanged to the execute stage for one cycle.

Parameters:
- XLEN, 64, width of register data and immediate paths.
- RADDR_W, 5, width of register-address fields.
- ALUOP_W, 2, width of ALU operation class field.

Ports:
- clk  input  1  system clock; all capture on rising edge.
- rst  input  1  asynchronous, active-low reset; 0 = reset asserted.
- AluSrc_in  input  1  ALU operand-B select (0 = rs2 data, 1 = immediate).
- MemtoReg_in  input  1  writeback select (1 = memory data).
- RegWrite_in  input  1  register-file write enable.
- MemRead_in  input  1  data-memory read enable.
- MemWrite_in  input  1  data-memory write enable.
- Aluop_in  input  ALUOP_W  ALU operation class from control unit.
- rs1Data_in  input  XLEN  register-file read data 1.
- rs2Data_in  input  XLEN  register-file read data 2.
- rs_in  input  RADDR_W  source register 1 address.
- rt_in  input  RADDR_W  source register 2 address.
- rd_in  input  RADDR_W  destination register address.
- immediate_in  input  XLEN  sign-extended immediate.
- AluSrc_out, MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out  output  1 each  registered copies of the matching inputs.
- Aluop_out  output  ALUOP_W  registered Aluop_in.
- rs1Data_out, rs2Data_out  output  XLEN  registered operand data.
- rs_out, rt_out, rd_out  output  RADDR_W  registered register addresses.
- immediate_out  output  XLEN  registered immediate.

Behaviour:
- Clocking and reset: one clock domain (clk). Reset is asynchronous and active-low (rst); no other reset source.
- While rst = 0: every output is forced to 0 immediately, without waiting for a clock edge. This covers all control bits, Aluop_out = 2'b00, data/immediate = 64'h0 and addresses = 5'h0. Outputs stay 0 for as long as rst is low, regardless of clk or inputs.
- Reset assertion mid-cycle: outputs clear at the moment rst falls, even between clock edges. Previously captured values are discarded.
- Reset release: rst rising has no effect on outputs by itself. The first rising clk edge with rst = 1 captures the inputs.
- Normal operation (rst = 1): at each rising clk edge, every output takes the value its input had just before the edge.
- Latency: exactly 1 cycle, input to output.
- Width rules: no transformation, extension or truncation; all fields are carried bit-exact.
- No enable, stall or flush: capture occurs on every edge. Bubble insertion is done upstream by driving zero control bits.
- Stability: outputs change only at a rising clk edge or at rst assertion. Input changes between edges are not visible at the outputs.
- Field independence: all fields are independent registers with no cross-field logic.
- X handling: no output may be X after reset assertion.

Test Plan:
1. Async reset: load all fields with nonzero values, then drive rst = 0 mid-cycle -> all outputs 0 before the next clk edge and held at 0 through 3 edges.
2. Zero capture after reset: rst = 1, all inputs 0, one edge -> all outputs 0 (Aluop_out = 00, rs1Data_out = 0000000000000000, immediate_out = 0).
3. Single capture: AluSrc = 1, MemtoReg = 1, RegWrite = 1, MemRead = 1, MemWrite = 0, Aluop = 2'b10, rs1Data = 64'hDEADBEEF_00000001, rs2Data = 64'h0123456789ABCDEF, rs = 5'd1, rt = 5'd2, rd = 5'd31, imm = 64'hFFFFFFFFFFFFFFF0 -> identical values on the outputs after 1 edge, unchanged before it.
4. Back-to-back: alternate all-ones and all-zeros on every field on consecutive edges -> outputs follow with 1-cycle lag and no dropped or duplicated cycle.
5. Mid-cycle input change: change rd_in from 5 to 9 between edges -> rd_out stays 5 until the next edge, then becomes 9.
6. Reset release timing: deassert rst between edges while inputs hold rd = 7 -> rd_out stays 0 until the next rising edge, then becomes 7.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: holds decode-stage control, operands, register
// addresses and immediate for one cycle on their way into the execute stage.
module id_ex_reg #(
    parameter int XLEN    = 64,
    parameter int RADDR_W = 5,
    parameter int ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               AluSrc_in,
    input  logic               MemtoReg_in,
    input  logic               RegWrite_in,
    input  logic               MemRead_in,
    input  logic               MemWrite_in,
    input  logic [ALUOP_W-1:0] Aluop_in,
    input  logic [XLEN-1:0]    rs1Data_in,
    input  logic [XLEN-1:0]    rs2Data_in,
    input  logic [RADDR_W-1:0] rs_in,
    input  logic [RADDR_W-1:0] rt_in,
    input  logic [RADDR_W-1:0] rd_in,
    input  logic [XLEN-1:0]    immediate_in,
    output logic               AluSrc_out,
    output logic               MemtoReg_out,
    output logic               RegWrite_out,
    output logic               MemRead_out,
    output logic               MemWrite_out,
    output logic [ALUOP_W-1:0] Aluop_out,
    output logic [XLEN-1:0]    rs1Data_out,
    output logic [XLEN-1:0]    rs2Data_out,
    output logic [RADDR_W-1:0] rs_out,
    output logic [RADDR_W-1:0] rt_out,
    output logic [RADDR_W-1:0] rd_out,
    output logic [XLEN-1:0]    immediate_out
);

    // Bubbles are created upstream by zeroing control bits, so every field
    // simply captures on each edge; there is no enable, stall or flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            AluSrc_out    <= 1'b0;
            MemtoReg_out  <= 1'b0;
            RegWrite_out  <= 1'b0;
            MemRead_out   <= 1'b0;
            MemWrite_out  <= 1'b0;
            Aluop_out     <= '0;
            rs1Data_out   <= '0;
            rs2Data_out   <= '0;
            rs_out        <= '0;
            rt_out        <= '0;
            rd_out        <= '0;
            immediate_out <= '0;
        end else begin
            AluSrc_out    <= AluSrc_in;
            MemtoReg_out  <= MemtoReg_in;
            RegWrite_out  <= RegWrite_in;
            MemRead_out   <= MemRead_in;
            MemWrite_out  <= MemWrite_in;
            Aluop_out     <= Aluop_in;
            rs1Data_out   <= rs1Data_in;
            rs2Data_out   <= rs2Data_in;
            rs_out        <= rs_in;
            rt_out        <= rt_in;
            rd_out        <= rd_in;
            immediate_out <= immediate_in;
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized self-checking bench for id_ex_reg; the reference model is
// "outputs equal the input bundle seen at the last rising edge, or zero in reset".
module tb_id_ex_reg;

    typedef struct packed {
        logic        alu_src;
        logic        mem_to_reg;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  aluop;
        logic [63:0] rs1_data;
        logic [63:0] rs2_data;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [63:0] imm;
    } fields_t;

    logic    clk;
    logic    rst;
    fields_t drv;
    fields_t obs;
    fields_t exp_reg;
    fields_t captured;
    int      checks;
    int      errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    id_ex_reg #(.XLEN(64), .RADDR_W(5), .ALUOP_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .AluSrc_in    (drv.alu_src),
        .MemtoReg_in  (drv.mem_to_reg),
        .RegWrite_in  (drv.reg_write),
        .MemRead_in   (drv.mem_read),
        .MemWrite_in  (drv.mem_write),
        .Aluop_in     (drv.aluop),
        .rs1Data_in   (drv.rs1_data),
        .rs2Data_in   (drv.rs2_data),
        .rs_in        (drv.rs),
        .rt_in        (drv.rt),
        .rd_in        (drv.rd),
        .immediate_in (drv.imm),
        .AluSrc_out   (obs.alu_src),
        .MemtoReg_out (obs.mem_to_reg),
        .RegWrite_out (obs.reg_write),
        .MemRead_out  (obs.mem_read),
        .MemWrite_out (obs.mem_write),
        .Aluop_out    (obs.aluop),
        .rs1Data_out  (obs.rs1_data),
        .rs2Data_out  (obs.rs2_data),
        .rs_out       (obs.rs),
        .rt_out       (obs.rt),
        .rd_out       (obs.rd),
        .immediate_out(obs.imm)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_fields(input string tag, input fields_t e);
        check({tag, ".AluSrc"},    64'(obs.alu_src),    64'(e.alu_src));
        check({tag, ".MemtoReg"},  64'(obs.mem_to_reg), 64'(e.mem_to_reg));
        check({tag, ".RegWrite"},  64'(obs.reg_write),  64'(e.reg_write));
        check({tag, ".MemRead"},   64'(obs.mem_read),   64'(e.mem_read));
        check({tag, ".MemWrite"},  64'(obs.mem_write),  64'(e.mem_write));
        check({tag, ".Aluop"},     64'(obs.aluop),      64'(e.aluop));
        check({tag, ".rs1Data"},   obs.rs1_data,        e.rs1_data);
        check({tag, ".rs2Data"},   obs.rs2_data,        e.rs2_data);
        check({tag, ".rs"},        64'(obs.rs),         64'(e.rs));
        check({tag, ".rt"},        64'(obs.rt),         64'(e.rt));
        check({tag, ".rd"},        64'(obs.rd),         64'(e.rd));
        check({tag, ".immediate"}, obs.imm,             e.imm);
        $display("txn %-12s t=%0t rst=%b rd_out=%0d imm_out=%h", tag, $time, rst, obs.rd, obs.imm);
    endtask

    function automatic fields_t rand_fields();
        fields_t f;
        f.alu_src    = 1'($urandom);
        f.mem_to_reg = 1'($urandom);
        f.reg_write  = 1'($urandom);
        f.mem_read   = 1'($urandom);
        f.mem_write  = 1'($urandom);
        f.aluop      = 2'($urandom);
        f.rs1_data   = {$urandom, $urandom};
        f.rs2_data   = {$urandom, $urandom};
        f.rs         = 5'($urandom);
        f.rt         = 5'($urandom);
        f.rd         = 5'($urandom);
        f.imm        = {$urandom, $urandom};
        return f;
    endfunction

    // Model one rising edge: whatever the inputs were at the edge becomes
    // the expected output if reset is not asserted. Sample 1 time unit later.
    task automatic edge_and_check(input string tag);
        captured = drv;
        @(posedge clk);
        if (rst) exp_reg = captured;
        else     exp_reg = '0;
        #1;
        check_fields(tag, exp_reg);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_reg = '0;
        rst     = 1'b0;
        drv     = rand_fields();

        // Outputs must be zero in reset before any clock edge has occurred.
        #2;
        check_fields("rst_init", '0);
        edge_and_check("rst_hold");

        // Release between edges with rd=7: no change until the next edge.
        drv = '0;
        drv.rd = 5'd7;
        #2;
        rst = 1'b1;
        #2;
        check_fields("rel_pre", '0);
        edge_and_check("rel_edge");

        // Zero capture.
        #1;
        drv = '0;
        edge_and_check("zero_cap");

        // Single directed capture; outputs must hold until the edge.
        #1;
        drv.alu_src    = 1'b1;
        drv.mem_to_reg = 1'b1;
        drv.reg_write  = 1'b1;
        drv.mem_read   = 1'b1;
        drv.mem_write  = 1'b0;
        drv.aluop      = 2'b10;
        drv.rs1_data   = 64'hDEADBEEF_00000001;
        drv.rs2_data   = 64'h0123456789ABCDEF;
        drv.rs         = 5'd1;
        drv.rt         = 5'd2;
        drv.rd         = 5'd31;
        drv.imm        = 64'hFFFFFFFFFFFFFFF0;
        #4;
        check_fields("single_pre", '0);
        edge_and_check("single");

        // Back-to-back all-ones / all-zeros on consecutive edges.
        for (int i = 0; i < 8; i++) begin
            #1;
            drv = (i % 2 == 0) ? '1 : '0;
            edge_and_check($sformatf("alt%0d", i));
        end

        // Mid-cycle rd change is invisible until the following edge.
        #1;
        drv.rd = 5'd5;
        edge_and_check("rd5");
        #2;
        drv.rd = 5'd9;
        #2;
        check_fields("rd_mid", exp_reg);
        edge_and_check("rd9");

        // Async reset mid-cycle with nonzero data loaded, held across 3 edges.
        #1;
        drv = '1;
        edge_and_check("load_ones");
        #2;
        rst = 1'b0;
        #1;
        exp_reg = '0;
        check_fields("async_clr", '0);
        for (int i = 0; i < 3; i++) begin
            drv = rand_fields();
            edge_and_check($sformatf("rst_edge%0d", i));
        end
        #2;
        rst = 1'b1;

        // Random traffic with occasional mid-cycle reset pulses.
        for (int i = 0; i < 150; i++) begin
            #1;
            drv = rand_fields();
            if ($urandom_range(0, 15) == 0) begin
                #1;
                rst = 1'b0;
                #1;
                exp_reg = '0;
                check_fields($sformatf("rnd_rst%0d", i), '0);
                #1;
                rst = 1'b1;
                #1;
                check_fields($sformatf("rnd_rel%0d", i), '0);
            end
            edge_and_check($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
